// File: rtl/decode_queue_ctrl_pkg.sv
// Shared sizing, encodings and pointer helper for the decode queue.
package decode_queue_ctrl_pkg;

   localparam int DQ_DEPTH    = 16;
   localparam int FETCH_NUM   = 4;
   localparam int DECODE_NUM  = 4;
   localparam int PC_WIDTH    = 64;

   localparam int PTR_W       = $clog2(DQ_DEPTH);
   localparam int CNT_W       = PTR_W + 1;
   localparam int FETCH_CNT_W = $clog2(FETCH_NUM + 1);
   localparam int DEC_CNT_W   = $clog2(DECODE_NUM + 1);

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef logic [PTR_W-1:0] dq_ptr_t;
   typedef logic [CNT_W-1:0] dq_count_t;

   // Circular-buffer index: wraps naturally in PTR_W bits.
   function automatic dq_ptr_t ptr_add(input dq_ptr_t base, input int unsigned offs);
      return base + dq_ptr_t'(offs);
   endfunction

endpackage

// File: rtl/decode_queue_ctrl_popcount.sv
// Lane-count of a per-lane valid mask (thermometer masks in practice).
module dq_popcount #(
   parameter int N  = 4,
   parameter int CW = $clog2(N + 1)
) (
   input  logic [N-1:0]  i_mask,
   output logic [CW-1:0] o_count
);

   // Sum of set lanes.
   always_comb begin
      o_count = '0;
      for (int k = 0; k < N; k++) begin
         o_count = o_count + CW'(i_mask[k]);
      end
   end

endmodule

// File: rtl/decode_queue_ctrl.sv
// Instruction queue between fetch and the decoder: FETCH_NUM-wide writes,
// DECODE_NUM-wide all-or-nothing group issue, flush discards everything.
module decode_queue_ctrl
   import decode_queue_ctrl_pkg::*;
(
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 flush,
   input  logic [FETCH_NUM-1:0]                 fetch_valid,
   input  logic [FETCH_NUM-1:0][31:0]           fetch_instr,
   input  logic [FETCH_NUM-1:0][PC_WIDTH-1:0]   fetch_pc,
   output logic                                 fetch_ready,
   output logic [DECODE_NUM-1:0]                dec_valid,
   output logic [DECODE_NUM-1:0][31:0]          dec_instr,
   output logic [DECODE_NUM-1:0][PC_WIDTH-1:0]  dec_pc,
   input  logic                                 dec_ready,
   output logic [CNT_W-1:0]                     dq_count
);

   dq_ptr_t               r_wr_ptr;
   dq_ptr_t               r_rd_ptr;
   dq_count_t             r_count;
   logic [31:0]           r_instr_mem [DQ_DEPTH];
   logic [PC_WIDTH-1:0]   r_pc_mem    [DQ_DEPTH];

   logic [FETCH_NUM-1:0]   w_push_mask;
   logic [DECODE_NUM-1:0]  w_pop_mask;
   logic [FETCH_CNT_W-1:0] w_push_n;
   logic [DEC_CNT_W-1:0]   w_pop_n;

   // Space test uses registered count only, so fetch never sees a same-cycle pop.
   assign fetch_ready = (r_count <= CNT_W'(DQ_DEPTH - FETCH_NUM));
   assign w_push_mask = fetch_ready ? fetch_valid : {FETCH_NUM{1'b0}};
   assign w_pop_mask  = dec_ready ? dec_valid : {DECODE_NUM{1'b0}};
   assign dq_count    = r_count;

   dq_popcount #(.N(FETCH_NUM), .CW(FETCH_CNT_W)) u_push_cnt (
      .i_mask  (w_push_mask),
      .o_count (w_push_n)
   );

   dq_popcount #(.N(DECODE_NUM), .CW(DEC_CNT_W)) u_pop_cnt (
      .i_mask  (w_pop_mask),
      .o_count (w_pop_n)
   );

   // Pointers and occupancy; reset and flush both empty the queue.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_n);
         r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop_n);
         r_count  <= r_count + CNT_W'(w_push_n) - CNT_W'(w_pop_n);
      end
   end

   // Storage write ports; contents are never cleared, only the pointers are.
   always_ff @(posedge clk) begin
      if (!rst && !flush) begin
         for (int k = 0; k < FETCH_NUM; k++) begin
            if (FETCH_CNT_W'(k) < w_push_n) begin
               r_instr_mem[ptr_add(r_wr_ptr, k)] <= fetch_instr[k];
               r_pc_mem[ptr_add(r_wr_ptr, k)]    <= fetch_pc[k];
            end
         end
      end
   end

   // Oldest entries onto decode lanes; empty lanes carry a NOP at pc 0.
   always_comb begin
      dec_valid = '0;
      dec_instr = '0;
      dec_pc    = '0;
      for (int i = 0; i < DECODE_NUM; i++) begin
         if (r_count > CNT_W'(i)) begin
            dec_valid[i] = 1'b1;
            dec_instr[i] = r_instr_mem[ptr_add(r_rd_ptr, i)];
            dec_pc[i]    = r_pc_mem[ptr_add(r_rd_ptr, i)];
         end else begin
            dec_valid[i] = 1'b0;
            dec_instr[i] = NOP_INSTR;
            dec_pc[i]    = '0;
         end
      end
   end

endmodule
